// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the processing-element controller: state encoding
// and default widths.
package pe_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_F = 3'd1,
    LOAD_I = 3'd2,
    MAC    = 3'd3,
    ACC    = 3'd4,
    OUT    = 3'd5
  } pe_state_e;

endpackage

// File: rtl/mod_counter.sv
// Up-counter that wraps to zero at a runtime modulus; clear has priority
// over enable.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count
);

  logic [W:0] inc;

  assign inc = {1'b0, count} + (W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (inc >= {1'b0, modulus}) ? '0 : inc[W-1:0];
    end
  end

endmodule

// File: rtl/pe_ctrl_fsm.sv
// Row-stationary PE sequencer: loads S weights, keeps an S-deep circular
// ifmap window, runs S MACs per output, adds the upstream psum, emits N psums.
module pe_ctrl_fsm
  import pe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_filt_size,
  input  logic [CNT_W-1:0]  cfg_num_out,
  output logic              busy,
  output logic              done,
  input  logic              filt_valid,
  output logic              filt_ready,
  input  logic              ifmap_valid,
  output logic              ifmap_ready,
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  output logic              psum_out_valid,
  input  logic              psum_out_ready,
  output logic              filt_we,
  output logic              ifmap_we,
  output logic [ADDR_W-1:0] filt_addr,
  output logic [ADDR_W-1:0] ifmap_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              acc_add_psum,
  output pe_state_e         dbg_state
);

  // Handshakes: a transfer happens only when valid and ready are both high in
  // the same cycle; every ready is decoded from state alone, never from valid.

  pe_state_e        state, next_state;
  logic [CNT_W-1:0] s_q, n_q, out_cnt;
  logic             need_full, done_q;
  logic [CNT_W-1:0] tap, wr_ptr, base;
  logic             accept, cfg_zero;
  logic             filt_hs, ifmap_hs, psin_hs, out_hs;
  logic             last_tap, last_out;
  logic             tap_en, base_en;
  logic [CNT_W:0]   win_sum, win_idx;

  // done_q blocks a start landing in the done cycle.
  assign accept   = (state == IDLE) && start && !done_q;
  assign cfg_zero = (cfg_filt_size == '0) || (cfg_num_out == '0);

  assign filt_hs  = (state == LOAD_F) && filt_valid;
  assign ifmap_hs = (state == LOAD_I) && ifmap_valid;
  assign psin_hs  = (state == ACC)    && psum_in_valid;
  assign out_hs   = (state == OUT)    && psum_out_ready;

  assign last_tap = (tap == s_q - CNT_W'(1));
  assign last_out = (out_cnt == n_q - CNT_W'(1));

  // One tap counter serves as k (weight load), the initial window fill and j
  // (MAC); each phase counts exactly S, so it is back at 0 for the next.
  assign tap_en  = filt_hs || (ifmap_hs && need_full) || (state == MAC);
  assign base_en = out_hs && !last_out;

  mod_counter #(.W(CNT_W)) u_tap (
    .clk(clk), .reset(reset), .en(tap_en), .clr(accept),
    .modulus(s_q), .count(tap)
  );

  mod_counter #(.W(CNT_W)) u_wr_ptr (
    .clk(clk), .reset(reset), .en(ifmap_hs), .clr(accept),
    .modulus(s_q), .count(wr_ptr)
  );

  mod_counter #(.W(CNT_W)) u_base (
    .clk(clk), .reset(reset), .en(base_en), .clr(accept),
    .modulus(s_q), .count(base)
  );

  assign win_sum = {1'b0, base} + {1'b0, tap};
  assign win_idx = (win_sum >= {1'b0, s_q}) ? (win_sum - {1'b0, s_q}) : win_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      out_cnt   <= '0;
      need_full <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (accept && cfg_zero) || (out_hs && last_out);
      if (accept) begin
        s_q       <= cfg_filt_size;
        n_q       <= cfg_num_out;
        out_cnt   <= '0;
        need_full <= 1'b1;
      end else if (out_hs) begin
        out_cnt   <= out_cnt + CNT_W'(1);
        need_full <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !cfg_zero) next_state = LOAD_F;
      LOAD_F:  if (filt_hs && last_tap) next_state = LOAD_I;
      LOAD_I:  if (ifmap_hs && (!need_full || last_tap)) next_state = MAC;
      MAC:     if (last_tap) next_state = ACC;
      ACC:     if (psin_hs) next_state = OUT;
      OUT:     if (out_hs) next_state = last_out ? IDLE : LOAD_I;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    done           = done_q;
    filt_ready     = (state == LOAD_F);
    ifmap_ready    = (state == LOAD_I);
    psum_in_ready  = (state == ACC);
    psum_out_valid = (state == OUT);
    filt_we        = filt_hs;
    ifmap_we       = ifmap_hs;
    mac_en         = (state == MAC);
    acc_clr        = (state == MAC) && (tap == '0);
    acc_add_psum   = psin_hs;
    filt_addr      = '0;
    ifmap_addr     = '0;
    if (state == LOAD_F || state == MAC) filt_addr = ADDR_W'(tap);
    if (state == LOAD_I) ifmap_addr = ADDR_W'(wr_ptr);
    if (state == MAC)    ifmap_addr = ADDR_W'(win_idx);
    dbg_state      = state;
  end

endmodule

// File: tb/tb_pe_ctrl_fsm.sv
// Directed bench for pe_ctrl_fsm: per-cycle output log, cycle-exact checks
// and an address scoreboard per job.
module tb_pe_ctrl_fsm;
  import pe_ctrl_pkg::*;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;
  localparam int MAXC   = 64;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [CNT_W-1:0]  cfg_filt_size, cfg_num_out;
  logic              busy, done;
  logic              filt_valid, filt_ready, ifmap_valid, ifmap_ready;
  logic              psum_in_valid, psum_in_ready, psum_out_valid, psum_out_ready;
  logic              filt_we, ifmap_we, mac_en, acc_clr, acc_add_psum;
  logic [ADDR_W-1:0] filt_addr, ifmap_addr;
  pe_state_e         dbg_state;

  typedef struct {
    logic busy, done, filt_ready, filt_we, ifmap_ready, ifmap_we;
    logic psum_in_ready, psum_out_valid, mac_en, acc_clr, acc_add_psum;
    logic [ADDR_W-1:0] filt_addr, ifmap_addr;
    logic [2:0] st;
  } rec_t;

  rec_t rec[MAXC];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_w[$];
  logic [ADDR_W-1:0] exp_f[$];

  pe_ctrl_fsm #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_filt_size(cfg_filt_size), .cfg_num_out(cfg_num_out),
    .busy(busy), .done(done),
    .filt_valid(filt_valid), .filt_ready(filt_ready),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .filt_we(filt_we), .ifmap_we(ifmap_we),
    .filt_addr(filt_addr), .ifmap_addr(ifmap_addr),
    .mac_en(mac_en), .acc_clr(acc_clr), .acc_add_psum(acc_add_psum),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_word(input rec_t r);
    return {13'd0, r.filt_addr | r.ifmap_addr, r.busy, r.done, r.filt_ready,
            r.filt_we, r.ifmap_ready, r.ifmap_we, r.psum_in_ready,
            r.psum_out_valid, r.mac_en, r.acc_clr, r.acc_add_psum};
  endfunction

  function automatic logic [31:0] live_outs();
    return {13'd0, filt_addr | ifmap_addr, busy, done, filt_ready, filt_we,
            ifmap_ready, ifmap_we, psum_in_ready, psum_out_valid, mac_en,
            acc_clr, acc_add_psum};
  endfunction

  // driver: start is sampled at edge 0, cycle c is the interval after edge c-1
  task automatic run_job(input int s, input int n, input int ncyc,
                         input int stall_from, input int stall_len, input bit toggle,
                         input int noise_a, input int noise_b, input int reset_at);
    cfg_filt_size = CNT_W'(s);
    cfg_num_out   = CNT_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < ncyc; c++) begin
      filt_valid     = 1'b1;
      psum_in_valid  = 1'b1;
      ifmap_valid    = toggle ? (c % 2 == 0) : 1'b1;
      psum_out_ready = !(c >= stall_from && c < stall_from + stall_len);
      start          = (c == noise_a) || (c == noise_b);
      if (c == reset_at) reset = 1'b1;
      else if (c == reset_at + 1) reset = 1'b0;
      @(negedge clk);
      rec[c].busy = busy;                     rec[c].done = done;
      rec[c].filt_ready = filt_ready;         rec[c].filt_we = filt_we;
      rec[c].ifmap_ready = ifmap_ready;       rec[c].ifmap_we = ifmap_we;
      rec[c].psum_in_ready = psum_in_ready;   rec[c].psum_out_valid = psum_out_valid;
      rec[c].mac_en = mac_en;                 rec[c].acc_clr = acc_clr;
      rec[c].acc_add_psum = acc_add_psum;
      rec[c].filt_addr = filt_addr;           rec[c].ifmap_addr = ifmap_addr;
      rec[c].st = dbg_state;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // scoreboard: address order, event counts and done cycle of one job
  task automatic scan(input string tag, input int s, input int n, input int ncyc,
                      input int done_cyc, input int out_cycles);
    int n_out, n_done, first_done, n_clr, n_add;
    exp_q.delete(); exp_w.delete(); exp_f.delete();
    for (int j = 0; j < s; j++) begin
      exp_f.push_back(ADDR_W'(j));
      exp_w.push_back(ADDR_W'(j));
    end
    for (int k = 1; k < n; k++) exp_w.push_back(ADDR_W'((k - 1) % s));
    for (int k = 0; k < n; k++)
      for (int j = 0; j < s; j++) begin
        exp_f.push_back(ADDR_W'(j));
        exp_q.push_back(ADDR_W'((k + j) % s));
      end
    n_out = 0; n_done = 0; first_done = -1; n_clr = 0; n_add = 0;
    for (int c = 1; c < ncyc; c++) begin
      if (rec[c].filt_we || rec[c].mac_en) begin
        if (exp_f.size() == 0) check({tag, " filt_addr extra"}, c, 0);
        else check($sformatf("%s filt_addr c%0d", tag, c), rec[c].filt_addr, exp_f.pop_front());
      end
      if (rec[c].mac_en) begin
        if (exp_q.size() == 0) check({tag, " mac_addr extra"}, c, 0);
        else check($sformatf("%s mac_ifmap_addr c%0d", tag, c), rec[c].ifmap_addr, exp_q.pop_front());
      end
      if (rec[c].ifmap_we) begin
        if (exp_w.size() == 0) check({tag, " we_addr extra"}, c, 0);
        else check($sformatf("%s we_ifmap_addr c%0d", tag, c), rec[c].ifmap_addr, exp_w.pop_front());
      end
      if (rec[c].psum_out_valid) n_out++;
      if (rec[c].acc_clr) n_clr++;
      if (rec[c].acc_add_psum) n_add++;
      if (rec[c].done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
    check({tag, " queues_drained"}, exp_q.size() + exp_w.size() + exp_f.size(), 0);
    check({tag, " out_valid_cycles"}, n_out, out_cycles);
    check({tag, " acc_clr_count"}, n_clr, n);
    check({tag, " acc_add_count"}, n_add, n);
    check({tag, " done_pulses"}, n_done, 1);
    check({tag, " done_cycle"}, first_done, done_cyc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    cfg_filt_size = '0; cfg_num_out = '0;
    filt_valid = 1'b0; ifmap_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", live_outs(), 0);
    check("reset_state", dbg_state, IDLE);
    @(posedge clk); #1;
    reset = 1'b0;

    // reset mid-MAC
    run_job(3, 2, 14, 0, 0, 1'b0, -1, -1, 8);
    check("rst_reached_mac", rec[7].mac_en, 1);
    check("rst_outs_c8", outs_word(rec[8]), 0);
    check("rst_outs_c9", outs_word(rec[9]), 0);
    check("rst_state_c9", rec[9].st, IDLE);
    check("rst_idle_c13", rec[13].busy, 0);

    // full job, all streams ready; start while busy and in the done cycle
    run_job(3, 2, 24, 0, 0, 1'b0, 5, 18, -1);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("a_filt_we c%0d", c), rec[c].filt_we, 1);
      check($sformatf("a_filt_addr c%0d", c), rec[c].filt_addr, c - 1);
    end
    check("a_filt_we c4", rec[4].filt_we, 0);
    check("a_out_c10", rec[10].psum_out_valid, 0);
    check("a_out_c11", rec[11].psum_out_valid, 1);
    check("a_out_c12", rec[12].psum_out_valid, 0);
    check("a_out_c17", rec[17].psum_out_valid, 1);
    check("a_done_c18", rec[18].done, 1);
    check("a_busy_c18", rec[18].busy, 0);
    check("a_ifmap_c13", rec[13].ifmap_addr, 1);
    check("a_ifmap_c14", rec[14].ifmap_addr, 2);
    check("a_ifmap_c15", rec[15].ifmap_addr, 0);
    check("a_clr_c13", rec[13].acc_clr, 1);
    check("a_clr_c14", rec[14].acc_clr, 0);
    check("a_clr_c15", rec[15].acc_clr, 0);
    check("a_start_in_done_ignored", rec[19].busy, 0);
    scan("a", 3, 2, 24, 18, 2);

    // psum_out backpressure for 4 cycles
    run_job(3, 2, 28, 11, 4, 1'b0, -1, -1, -1);
    for (int c = 11; c <= 15; c++) begin
      check($sformatf("bp_out_held c%0d", c), rec[c].psum_out_valid, 1);
      check($sformatf("bp_state c%0d", c), rec[c].st, OUT);
      check($sformatf("bp_addr c%0d", c), rec[c].filt_addr | rec[c].ifmap_addr, 0);
    end
    check("bp_load_c16", rec[16].ifmap_we, 1);
    check("bp_out_c21", rec[21].psum_out_valid, 1);
    scan("bp", 3, 2, 28, 22, 6);

    // ifmap_valid toggling 1,0,1,0 in LOAD_I
    run_job(3, 2, 24, 0, 0, 1'b1, -1, -1, -1);
    check("tg_we_c4", rec[4].ifmap_we, 1);
    check("tg_we_c5", rec[5].ifmap_we, 0);
    check("tg_ready_c5", rec[5].ifmap_ready, 1);
    check("tg_we_c6", rec[6].ifmap_we, 1);
    check("tg_we_c7", rec[7].ifmap_we, 0);
    check("tg_addr_c8", rec[8].ifmap_addr, 2);
    check("tg_mac_c9", rec[9].mac_en, 1);
    check("tg_wrap_c14", rec[14].ifmap_addr, 0);
    check("tg_out_c13", rec[13].psum_out_valid, 1);
    check("tg_out_c19", rec[19].psum_out_valid, 1);
    scan("tg", 3, 2, 24, 20, 2);

    // S=1 single-entry window, S=2 base wrap
    run_job(1, 3, 18, 0, 0, 1'b0, -1, -1, -1);
    check("s1_clr_c3", rec[3].acc_clr, 1);
    check("s1_clr_c7", rec[7].acc_clr, 1);
    check("s1_out_c9", rec[9].psum_out_valid, 1);
    scan("s1", 1, 3, 18, 14, 3);
    run_job(2, 3, 24, 0, 0, 1'b0, -1, -1, -1);
    scan("s2", 2, 3, 24, 19, 3);

    // zero-size configurations
    run_job(3, 0, 5, 0, 0, 1'b0, -1, -1, -1);
    check("n0_done_c1", rec[1].done, 1);
    check("n0_done_c2", rec[2].done, 0);
    for (int c = 1; c <= 4; c++) check($sformatf("n0_busy c%0d", c), rec[c].busy, 0);
    run_job(0, 2, 5, 0, 0, 1'b0, -1, -1, -1);
    check("s0_done_c1", rec[1].done, 1);
    check("s0_busy_c1", rec[1].busy, 0);
    check("s0_filt_ready_c2", rec[2].filt_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
